// File: rtl/image_decoder_grid.sv
// Mouse-to-bitmap decoder: 2-stage coordinate pipeline, paint/erase/clear and a
// valid/ready frame-submit port. Define BRUSH_3X3_EN for a 3x3 brush.
module image_decoder_grid #(
  parameter int GRID_W          = 14,
  parameter int GRID_H          = 14,
  parameter int CELL_W          = 10,
  parameter int CELL_H          = 14,
  parameter int X0              = 90,
  parameter int Y0              = 34,
  parameter int COORD_W         = 9,
  parameter bit CLEAR_ON_SUBMIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COORD_W-1:0]         xpos,
  input  logic [COORD_W-1:0]         ypos,
  input  logic                       leftclick,
  input  logic                       rightclick,
  input  logic                       clear,
  input  logic                       submit,
  output logic [GRID_W*GRID_H-1:0]   img,
  output logic [GRID_W*GRID_H-1:0]   img_out,
  output logic                       out_valid,
  input  logic                       out_ready
);
  localparam int NPIX = GRID_W * GRID_H;
  localparam logic [COORD_W-1:0] X0_C     = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0_C     = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] CELL_W_C = COORD_W'(CELL_W);
  localparam logic [COORD_W-1:0] CELL_H_C = COORD_W'(CELL_H);
  localparam logic [COORD_W-1:0] GRID_W_C = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GRID_H_C = COORD_W'(GRID_H);

  // vld_pipe[0] = stage 1 holds an op, vld_pipe[1] = stage 2 holds an op
  logic [1:0]         vld_pipe_q, vld_pipe_d;
  logic               s1_erase_q, s1_erase_d;
  logic               s1_under_q, s1_under_d;
  logic [COORD_W-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic               s2_erase_q, s2_erase_d;
  logic               s2_inr_q, s2_inr_d;
  logic [COORD_W-1:0] s2_col_q, s2_col_d, s2_row_q, s2_row_d;
  logic [NPIX-1:0]    img_q, img_d, img_out_q, img_out_d;
  logic               out_valid_q, out_valid_d;
  logic               accept, clr_eff;
  logic [COORD_W-1:0] col_c, row_c;
  logic [NPIX-1:0]    cell_hit;

  assign accept  = submit & (~out_valid_q | out_ready);
  assign clr_eff = clear | (CLEAR_ON_SUBMIT & accept);
  assign col_c   = s1_dx_q / CELL_W_C;
  assign row_c   = s1_dy_q / CELL_H_C;

  always_comb begin
    vld_pipe_d = {1'b0, leftclick | rightclick};
    s1_erase_d = rightclick;
    s1_dx_d    = xpos - X0_C;
    s1_dy_d    = ypos - Y0_C;
    s1_under_d = (xpos < X0_C) | (ypos < Y0_C);
    s2_erase_d = s1_erase_q;
    s2_col_d   = col_c;
    s2_row_d   = row_c;
    s2_inr_d   = ~s1_under_q & (col_c < GRID_W_C) & (row_c < GRID_H_C);
    // a clear kills the op moving into stage 2; the stage-2 op is blocked below
    vld_pipe_d[1] = vld_pipe_q[0] & ~clr_eff;
  end

  // per-cell write decode against the stage-2 target
  for (genvar r = 0; r < GRID_H; r++) begin : g_row
    for (genvar c = 0; c < GRID_W; c++) begin : g_col
      int dr, dc;
      assign dr = r - int'(s2_row_q);
      assign dc = c - int'(s2_col_q);
`ifdef BRUSH_3X3_EN
      assign cell_hit[r*GRID_W+c] = vld_pipe_q[1] & s2_inr_q &
                                    (dr >= -1) & (dr <= 1) & (dc >= -1) & (dc <= 1);
`else
      assign cell_hit[r*GRID_W+c] = vld_pipe_q[1] & s2_inr_q & (dr == 0) & (dc == 0);
`endif
    end
  end

  always_comb begin
    img_d = img_q;
    if (clr_eff) begin
      img_d = '0;
    end else begin
      for (int i = 0; i < NPIX; i++)
        if (cell_hit[i]) img_d[i] = ~s2_erase_q;
    end
  end

  // snapshot takes the pre-edge bitmap, so same-edge writes and clears are excluded
  always_comb begin
    img_out_d   = img_out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      img_out_d   = img_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q  <= '0;
      s1_erase_q  <= 1'b0;
      s1_under_q  <= 1'b0;
      s1_dx_q     <= '0;
      s1_dy_q     <= '0;
      s2_erase_q  <= 1'b0;
      s2_inr_q    <= 1'b0;
      s2_col_q    <= '0;
      s2_row_q    <= '0;
      img_q       <= '0;
      img_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      s1_erase_q  <= s1_erase_d;
      s1_under_q  <= s1_under_d;
      s1_dx_q     <= s1_dx_d;
      s1_dy_q     <= s1_dy_d;
      s2_erase_q  <= s2_erase_d;
      s2_inr_q    <= s2_inr_d;
      s2_col_q    <= s2_col_d;
      s2_row_q    <= s2_row_d;
      img_q       <= img_d;
      img_out_q   <= img_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign img       = img_q;
  assign img_out   = img_out_q;
  assign out_valid = out_valid_q;
endmodule
